pic_ack_sequencer: RTL

Interrupt acknowledge sequencer and priority arbiter for the 8259A-compatible PIC. It captures eight IR request lines into the IRR, masks them with the IMR, and resolves the winner against the in-service register (ISR) using fully nested priority. It drives the INT request and runs the two-pulse INTA handshake: it sets and clears ISR bits through a one-hot level decode and delivers the 8-bit vector to the data-bus interface.

---
 rtl/pic_ack_sequencer_if.sv | 26 ++
 rtl/pic_ack_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pic_ack_sequencer_if.sv
// Bus-side bundle for pic_ack_sequencer: request/mask/EOI inputs and INT/vector/status outputs.
interface pic_ack_sequencer_if;
    logic [7:0] ir;
    logic       ltim;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       inta;
    logic       eoi;
    logic       seoi;
    logic [2:0] seoi_lvl;
    logic       int_req;
    logic [7:0] vector;
    logic       vec_valid;
    logic [7:0] isr;
    logic [7:0] irr;

    modport master (
        output ir, ltim, imr, vec_base, inta, eoi, seoi, seoi_lvl,
        input  int_req, vector, vec_valid, isr, irr
    );

    modport slave (
        input  ir, ltim, imr, vec_base, inta, eoi, seoi, seoi_lvl,
        output int_req, vector, vec_valid, isr, irr
    );
endinterface

// File: rtl/pic_ack_sequencer.sv
// 8259A-style IRR/ISR fully nested priority arbiter with two-pulse INTA sequencer.
// Optional macro PIC_ROTATE_EN: a non-specific EOI makes the cleared level lowest priority.
module pic_ack_sequencer #(
    parameter logic [2:0] SPURIOUS_LVL = 3'd7,
    parameter bit         AEOI         = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    pic_ack_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK1 = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [7:0] r_ir_q;
    logic [7:0] r_vector;
    logic       r_int_req;
    logic       r_vec_valid;
    logic       r_spur;
    logic [2:0] r_lvl;

    logic [2:0] w_pri_low;
    logic [2:0] w_start;
    logic [7:0] w_cand;
    logic [7:0] w_grant_mask;
    logic [7:0] w_eoi_mask;
    logic [7:0] w_irr_nxt;
    logic       w_win_found;
    logic       w_isr_found;
    logic       w_win_valid;
    logic       w_grant;
    logic       w_ack2;
    logic [2:0] w_win_lvl;
    logic [2:0] w_isr_lvl;
    logic [2:0] w_win_rank;
    logic [2:0] w_isr_rank;

    // Returns {found, level} of the first set bit scanning upward from start with wrap.
    function automatic logic [3:0] f_first(input logic [7:0] req, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            lvl = start + k[2:0];
            if (req[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

`ifdef PIC_ROTATE_EN
    logic [2:0] r_pri_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pri_low <= 3'd7;
        end else if (bus.eoi && w_isr_found) begin
            r_pri_low <= w_isr_lvl;
        end
    end

    assign w_pri_low = r_pri_low;
`else
    assign w_pri_low = 3'd7;
`endif

    // Ranks are distances from the highest-priority level, so plain compares work under rotation.
    always_comb begin
        w_start                  = w_pri_low + 3'd1;
        w_cand                   = r_irr & ~bus.imr;
        {w_win_found, w_win_lvl} = f_first(w_cand, w_start);
        {w_isr_found, w_isr_lvl} = f_first(r_isr, w_start);
        w_win_rank               = w_win_lvl - w_start;
        w_isr_rank               = w_isr_lvl - w_start;
        w_win_valid              = w_win_found && (!w_isr_found || (w_win_rank < w_isr_rank));
        w_grant                  = (r_state == S_PEND) && bus.inta && w_win_valid;
        w_ack2                   = (r_state == S_ACK1) && bus.inta;
        w_grant_mask             = w_grant ? (8'd1 << w_win_lvl) : 8'd0;

        w_eoi_mask = 8'd0;
        if (bus.eoi && w_isr_found) w_eoi_mask = w_eoi_mask | (8'd1 << w_isr_lvl);
        if (bus.seoi)               w_eoi_mask = w_eoi_mask | (8'd1 << bus.seoi_lvl);
        if (AEOI && w_ack2 && !r_spur) w_eoi_mask = w_eoi_mask | (8'd1 << r_lvl);

        if (bus.ltim) begin
            w_irr_nxt = bus.ir & ~w_grant_mask;
        end else begin
            w_irr_nxt = (r_irr | (bus.ir & ~r_ir_q)) & ~w_grant_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_irr       <= 8'd0;
            r_isr       <= 8'd0;
            r_ir_q      <= 8'd0;
            r_vector    <= 8'd0;
            r_int_req   <= 1'b0;
            r_vec_valid <= 1'b0;
            r_spur      <= 1'b0;
            r_lvl       <= 3'd0;
        end else begin
            r_ir_q      <= bus.ir;
            r_irr       <= w_irr_nxt;
            r_isr       <= (r_isr & ~w_eoi_mask) | w_grant_mask;
            r_vec_valid <= w_ack2;
            if (w_ack2) r_vector <= {bus.vec_base, r_lvl};

            // An INTA that finds no valid winner still completes the handshake as spurious.
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_int_req <= 1'b1;
                        r_state   <= S_PEND;
                    end else if (bus.inta) begin
                        r_lvl   <= SPURIOUS_LVL;
                        r_spur  <= 1'b1;
                        r_state <= S_ACK1;
                    end
                end
                S_PEND: begin
                    if (bus.inta) begin
                        r_int_req <= 1'b0;
                        r_state   <= S_ACK1;
                        if (w_win_valid) begin
                            r_lvl  <= w_win_lvl;
                            r_spur <= 1'b0;
                        end else begin
                            r_lvl  <= SPURIOUS_LVL;
                            r_spur <= 1'b1;
                        end
                    end else if (!w_win_valid) begin
                        r_int_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_ACK1: begin
                    if (bus.inta) r_state <= S_IDLE;
                end
                default: begin
                    r_int_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.int_req   = r_int_req;
    assign bus.vector    = r_vector;
    assign bus.vec_valid = r_vec_valid;
    assign bus.isr       = r_isr;
    assign bus.irr       = r_irr;
endmodule
